bsg_popcount_seq: RTL and testbench



---
 rtl/bsg_popcount_seq.sv | 68 ++++++
 tb/tb_bsg_popcount_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bsg_popcount_seq.sv
// bsg_popcount_seq: multi-cycle popcount of a width_p-bit word, slice_width_p bits per cycle
// Ports: clk_i/reset_i (sync active-high); v_i/data_i/ready_o input handshake;
//        v_o/data_o/yumi_i output handshake carrying the set-bit count.
module bsg_popcount_seq #(
  parameter int width_p = 64,
  parameter int slice_width_p = 16,
  localparam int els_lp = (width_p + slice_width_p - 1) / slice_width_p,
  localparam int cnt_width_lp = $clog2(width_p + 1),
  localparam int ctr_width_lp = (els_lp > 1) ? $clog2(els_lp) : 1,
  localparam int sc_width_lp = $clog2(slice_width_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    v_i,
  input  logic [width_p-1:0]      data_i,
  output logic                    ready_o,
  output logic                    v_o,
  output logic [cnt_width_lp-1:0] data_o,
  input  logic                    yumi_i
);
  typedef enum logic [1:0] {eIdle, eBusy, eDone} state_e;
  state_e state_r, state_n;
  logic [width_p-1:0] shift_r;
  logic [cnt_width_lp-1:0] acc_r;
  logic [ctr_width_lp-1:0] ctr_r;
  logic [sc_width_lp-1:0] slice_cnt;
  logic accept, last;
  assign accept = v_i & ready_o;
  assign last = ctr_r == ctr_width_lp'(els_lp - 1);
  always_ff @(posedge clk_i)
    state_r <= reset_i ? eIdle : state_n;
  always_comb begin
    state_n = state_r;
    case (state_r)
      eIdle:   state_n = accept ? eBusy : eIdle;
      eBusy:   state_n = last ? eDone : eBusy;
      eDone:   state_n = yumi_i ? (v_i ? eBusy : eIdle) : eDone;
      default: state_n = eIdle;
    endcase
  end
  // Outputs are forced low during reset so an in-flight result vanishes in the reset cycle.
  always_comb begin
    ready_o = ~reset_i & ((state_r == eIdle) | ((state_r == eDone) & yumi_i));
    v_o = ~reset_i & (state_r == eDone);
    data_o = reset_i ? '0 : acc_r;
  end
  always_comb begin
    slice_cnt = '0;
    for (int i = 0; i < slice_width_p; i++)
      slice_cnt = slice_cnt + sc_width_lp'(shift_r[i]);
  end
  // Zero-filling shift means a ragged final slice contributes only real bits.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shift_r <= '0;
      acc_r <= '0;
      ctr_r <= '0;
    end else if (accept) begin
      shift_r <= data_i;
      acc_r <= '0;
      ctr_r <= '0;
    end else if (state_r == eBusy) begin
      shift_r <= shift_r >> slice_width_p;
      acc_r <= acc_r + cnt_width_lp'(slice_cnt);
      ctr_r <= ctr_r + ctr_width_lp'(1);
    end
  end
endmodule

// File: tb/tb_bsg_popcount_seq.sv
// tb_bsg_popcount_seq: directed and random checks of bsg_popcount_seq in three configurations
module tb_bsg_popcount_seq;
  logic clk = 0;
  logic rst;
  logic [2:0] v, yumi, ready, vo;
  logic [63:0] dat;
  logic [6:0] do64;
  logic [5:0] do40;
  logic [3:0] do8;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  bsg_popcount_seq #(.width_p(64), .slice_width_p(16)) u64 (
    .clk_i(clk), .reset_i(rst), .v_i(v[0]), .data_i(dat), .ready_o(ready[0]),
    .v_o(vo[0]), .data_o(do64), .yumi_i(yumi[0]));
  bsg_popcount_seq #(.width_p(40), .slice_width_p(16)) u40 (
    .clk_i(clk), .reset_i(rst), .v_i(v[1]), .data_i(dat[39:0]), .ready_o(ready[1]),
    .v_o(vo[1]), .data_o(do40), .yumi_i(yumi[1]));
  bsg_popcount_seq #(.width_p(8), .slice_width_p(8)) u8 (
    .clk_i(clk), .reset_i(rst), .v_i(v[2]), .data_i(dat[7:0]), .ready_o(ready[2]),
    .v_o(vo[2]), .data_o(do8), .yumi_i(yumi[2]));
  typedef struct {int k; logic [63:0] d; int e; int lat; string nm;} vec_t;
  vec_t tbl[8];
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic int dout(input int k);
    return k == 0 ? int'(do64) : k == 1 ? int'(do40) : int'(do8);
  endfunction
  task automatic run(input int k, input logic [63:0] w, input int e, input int lat, input string nm);
    v[k] = 1;
    dat = w;
    #1;
    chk({nm, " ready idle"}, int'(ready[k]), 1);
    tick;
    v[k] = 0;
    dat = ~w;
    #1;
    for (int c = 1; c < lat; c++) begin
      chk({nm, " busy v/ready"}, int'({vo[k], ready[k]}), 0);
      tick;
    end
    chk({nm, " v_o at latency"}, int'(vo[k]), 1);
    chk({nm, " data"}, dout(k), e);
    tick;
    chk({nm, " held v/ready"}, int'({vo[k], ready[k]}), 2);
    chk({nm, " held data"}, dout(k), e);
    yumi[k] = 1;
    #1;
    chk({nm, " ready on yumi"}, int'(ready[k]), 1);
    tick;
    yumi[k] = 0;
    #1;
    chk({nm, " idle after yumi"}, int'({vo[k], ready[k]}), 1);
  endtask
  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [63:0] ws[3];
    int es[3];
    int idx, res, cyc, cnt, seen;
    logic [63:0] w;
    tbl[0] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64, 5, "ones64"};
    tbl[1] = '{0, 64'h0, 0, 5, "zero64"};
    tbl[2] = '{0, 64'h8000_0000_0000_0001, 2, 5, "ends64"};
    tbl[3] = '{0, 64'h00FF_0000_F0F0_0001, 17, 5, "sparse64"};
    tbl[4] = '{0, 64'hAAAA_AAAA_AAAA_AAAA, 32, 5, "alt64"};
    tbl[5] = '{1, 64'hFF_FFFF_FFFF, 40, 4, "ones40"};
    tbl[6] = '{1, 64'h80_0000_0001, 2, 4, "ends40"};
    tbl[7] = '{2, 64'hA5, 4, 2, "a5_8"};
    rst = 1;
    v = 0;
    yumi = 0;
    dat = 0;
    repeat (2) tick;
    for (int k = 0; k < 3; k++) begin
      chk("reset v/ready", int'({vo[k], ready[k]}), 0);
      chk("reset data", dout(k), 0);
    end
    rst = 0;
    tick;
    chk("ready after reset", int'(ready), 7);
    foreach (tbl[i]) run(tbl[i].k, tbl[i].d, tbl[i].e, tbl[i].lat, tbl[i].nm);
    ws = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h1};
    es = '{64, 0, 1};
    v[0] = 1;
    dat = ws[0];
    idx = 1;
    res = 0;
    tick;
    cyc = 1;
    while (res < 3 && cyc < 40) begin
      if (vo[0]) begin
        chk("b2b data", dout(0), es[res]);
        chk("b2b cycle", cyc, 5 * (res + 1));
        res++;
        yumi[0] = 1;
        if (idx < 3) begin
          dat = ws[idx];
          idx++;
        end else v[0] = 0;
      end else begin
        yumi[0] = 0;
        dat = 64'hDEAD_BEEF_0F0F_3C3C;
      end
      tick;
      cyc++;
    end
    yumi[0] = 0;
    v[0] = 0;
    chk("b2b results", res, 3);
    seen = 0;
    repeat (8) begin
      seen |= int'(vo[0]);
      tick;
    end
    chk("b2b no extra result", seen, 0);
    v[0] = 1;
    dat = 64'hFFFF_FFFF_FFFF_FFFF;
    tick;
    v[0] = 0;
    tick;
    rst = 1;
    #1;
    chk("rst busy v/ready", int'({vo[0], ready[0]}), 0);
    chk("rst busy data", dout(0), 0);
    tick;
    rst = 0;
    #1;
    chk("post rst busy ready", int'({vo[0], ready[0]}), 1);
    seen = 0;
    repeat (8) begin
      seen |= int'(vo[0]);
      tick;
    end
    chk("discarded word no v_o", seen, 0);
    run(0, 64'hFFFF_FFFF_FFFF_FFFF, 64, 5, "after rst");
    v[0] = 1;
    dat = 64'h0F;
    tick;
    v[0] = 0;
    repeat (6) tick;
    chk("done before rst v_o", int'(vo[0]), 1);
    chk("done before rst data", dout(0), 4);
    rst = 1;
    #1;
    chk("rst done v_o", int'(vo[0]), 0);
    chk("rst done data", dout(0), 0);
    tick;
    rst = 0;
    #1;
    chk("post rst done", int'({vo[0], ready[0]}), 1);
    for (int n = 0; n < 1000; n++) begin
      w = {$urandom, $urandom};
      if (n % 3 == 1) w = w & {$urandom, $urandom} & {$urandom, $urandom};
      v[0] = 1;
      dat = w;
      tick;
      v[0] = 0;
      dat = ~w;
      cnt = 0;
      while (!vo[0] && cnt < 20) begin
        tick;
        cnt++;
      end
      chk("rand latency", cnt, 4);
      repeat ($urandom_range(0, 3)) tick;
      chk("rand data", dout(0), $countones(w));
      yumi[0] = 1;
      tick;
      yumi[0] = 0;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
